lut_softmax_seq: RTL and testbench

//  Sequential, handshaked successor of the combinational LUT softmax. Accepts one vector of up to

---
 rtl/lut_softmax_seq_pkg.sv | 21 ++
 rtl/lut_softmax_seq_if.sv | 13 +
 rtl/lut_softmax_seq_recip_div.sv | 41 ++++
 rtl/lut_softmax_seq.sv | 93 +++++++++
 tb/tb_lut_softmax_seq.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/lut_softmax_seq_pkg.sv
// lut_softmax_seq_pkg: shared widths, FSM states and exp ROM for the LUT softmax
package lut_softmax_seq_pkg;
  localparam int DATACOUNT = 10;
  localparam int IN_INT = 6;
  localparam int IN_FRAC = 2;
  localparam int LUT_INT = 4;
  localparam int F = 12;
  localparam int IW = IN_INT + IN_FRAC;
  localparam int OW = LUT_INT + F;
  localparam int LW = $clog2(DATACOUNT + 1);
  localparam int SW = OW + $clog2(DATACOUNT);
  localparam int DW = SW + F;
  typedef enum logic [2:0] {IDLE, MAX, EXP, DIV, NORM, DONE} state_t;
  typedef logic [OW-1:0] lut_t [2**IW];
  function automatic lut_t exp_lut_init();
    lut_t t;
    for (int k = 0; k < 2**IW; k++)
      t[k] = OW'($rtoi($exp(-real'(k) / real'(2**IN_FRAC)) * real'(2**F) + 0.5));
    return t;
  endfunction
endpackage

// File: rtl/lut_softmax_seq_if.sv
// lut_softmax_seq_if: valid/ready logit input and probability output bundle
interface lut_softmax_seq_if;
  import lut_softmax_seq_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [LW-1:0] in_len;
  logic [DATACOUNT-1:0][IW-1:0] softmaxInput;
  logic out_valid;
  logic out_ready;
  logic [DATACOUNT-1:0][OW-1:0] softmaxOutput;
  modport master (output in_valid, in_len, softmaxInput, out_ready, input in_ready, out_valid, softmaxOutput);
  modport slave (input in_valid, in_len, softmaxInput, out_ready, output in_ready, out_valid, softmaxOutput);
endinterface

// File: rtl/lut_softmax_seq_recip_div.sv
// lut_softmax_seq_recip_div: bit-serial restoring divider giving floor(2^(2F)/sum), MSB first
module lut_softmax_seq_recip_div
  import lut_softmax_seq_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic [SW-1:0] i_sum,
  output logic          o_busy,
  output logic          o_done,
  output logic [F:0]    o_recip
);
  localparam int CW = $clog2(F + 1);
  logic          r_busy;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_rem, r_div, w_rem, w_div;
  logic [F:0]    r_q;
  logic          w_ge;
  assign w_rem = i_start ? DW'(1) << (2 * F) : r_rem;
  assign w_div = i_start ? DW'(i_sum) << F : r_div;
  assign w_ge = w_rem >= w_div;
  assign o_busy = r_busy;
  assign o_done = r_busy && r_cnt == CW'(F);
  assign o_recip = r_q;
  // the start cycle already resolves the top quotient bit, so F+1 bits take F+1 cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_cnt <= '0;
      r_rem <= '0;
      r_div <= '0;
      r_q <= '0;
    end else if (i_start || r_busy) begin
      r_rem <= w_ge ? w_rem - w_div : w_rem;
      r_div <= w_div >> 1;
      r_q <= {r_q[F-1:0], w_ge};
      r_cnt <= i_start ? CW'(1) : r_cnt + 1'b1;
      r_busy <= !o_done;
    end
  end
endmodule

// File: rtl/lut_softmax_seq.sv
// lut_softmax_seq: sequential LUT softmax with max-subtract, reciprocal divide and scaling
module lut_softmax_seq
  import lut_softmax_seq_pkg::*;
(
  input logic clk,
  input logic rst_n,
  lut_softmax_seq_if.slave bus
);
  localparam lut_t LUT = exp_lut_init();
  state_t r_state, w_next;
  logic [LW-1:0] r_len, r_idx, w_len;
  logic [DATACOUNT-1:0][IW-1:0] r_x;
  logic [DATACOUNT-1:0][OW-1:0] r_exp, r_out;
  logic signed [IW-1:0] r_max, w_x;
  logic [IW-1:0] w_lut_idx;
  logic [OW-1:0] w_e, w_norm;
  logic [SW-1:0] r_sum;
  logic [F:0] w_recip;
  logic w_last, w_div_start, w_div_busy, w_div_done;
  assign w_len = (bus.in_len == '0 || bus.in_len > LW'(DATACOUNT)) ? LW'(DATACOUNT) : bus.in_len;
  assign w_last = r_idx + 1'b1 == r_len;
  assign w_x = $signed(r_x[r_idx]);
  assign w_lut_idx = r_max - w_x;
  assign w_e = LUT[w_lut_idx];
  assign w_norm = OW'((DW'(r_exp[r_idx]) * DW'(w_recip)) >> F);
  assign w_div_start = r_state == DIV && !w_div_busy;
  assign bus.in_ready = r_state == IDLE;
  assign bus.out_valid = r_state == DONE;
  assign bus.softmaxOutput = r_out;
  lut_softmax_seq_recip_div u_div (
    .clk(clk),
    .rst_n(rst_n),
    .i_start(w_div_start),
    .i_sum(r_sum),
    .o_busy(w_div_busy),
    .o_done(w_div_done),
    .o_recip(w_recip)
  );
  // state register
  always_ff @(posedge clk) r_state <= !rst_n ? IDLE : w_next;
  // each phase walks the L elements, except DIV which waits for the divider
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = bus.in_valid ? MAX : IDLE;
      MAX: w_next = w_last ? EXP : MAX;
      EXP: w_next = w_last ? DIV : EXP;
      DIV: w_next = w_div_done ? NORM : DIV;
      NORM: w_next = w_last ? DONE : NORM;
      DONE: w_next = bus.out_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  // datapath: exp buffer is zeroed on accept so unused lanes normalise to 0, and is then reused in place for the scaled results
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_len <= '0;
      r_idx <= '0;
      r_x <= '0;
      r_max <= '0;
      r_sum <= '0;
      r_exp <= '0;
      r_out <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.in_valid) begin
          r_x <= bus.softmaxInput;
          r_len <= w_len;
          r_idx <= '0;
          r_max <= $signed(bus.softmaxInput[0]);
          r_sum <= '0;
          r_exp <= '0;
        end
        MAX: begin
          r_max <= w_x > r_max ? w_x : r_max;
          r_idx <= w_last ? '0 : r_idx + 1'b1;
        end
        EXP: begin
          r_exp[r_idx] <= w_e;
          r_sum <= r_sum + SW'(w_e);
          r_idx <= w_last ? '0 : r_idx + 1'b1;
        end
        NORM: begin
          r_exp[r_idx] <= w_norm;
          r_idx <= w_last ? '0 : r_idx + 1'b1;
          if (w_last)
            for (int j = 0; j < DATACOUNT; j++) r_out[j] <= LW'(j) == r_idx ? w_norm : r_exp[j];
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lut_softmax_seq.sv
// tb_lut_softmax_seq: table vectors, corner sequences and random vectors against a real-arithmetic softmax model
module tb_lut_softmax_seq;
  import lut_softmax_seq_pkg::*;
  typedef logic [DATACOUNT-1:0][IW-1:0] vin_t;
  typedef logic [DATACOUNT-1:0][OW-1:0] vout_t;
  typedef struct {logic [LW-1:0] len; vin_t x; vout_t y; int lat;} vec_t;
  logic clk = 1'b0;
  logic rst_n;
  int n_pass = 0;
  int n_total = 0;
  vec_t tab[6];
  lut_softmax_seq_if bus();
  lut_softmax_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic check(string nm, longint act, longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask
  task automatic checkv(string nm, vout_t act, vout_t exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  function automatic void model(input logic [LW-1:0] len, input vin_t x, output vout_t y, output int lat);
    int l, mx;
    longint e[DATACOUNT];
    longint sum = 0;
    longint recip;
    l = (len == 0 || int'(len) > DATACOUNT) ? DATACOUNT : int'(len);
    mx = -(1 << 30);
    for (int i = 0; i < l; i++) if (int'($signed(x[i])) > mx) mx = int'($signed(x[i]));
    for (int i = 0; i < DATACOUNT; i++) begin
      e[i] = (i < l) ? longint'($rtoi($exp(-real'(mx - int'($signed(x[i]))) / 4.0) * 4096.0 + 0.5)) : 0;
      sum += e[i];
    end
    recip = (longint'(1) << 24) / sum;
    y = '0;
    for (int i = 0; i < l; i++) y[i] = OW'((e[i] * recip) >> 12);
    lat = 3 * l + 13;
  endfunction
  task automatic send(string nm, logic [LW-1:0] len, vin_t x);
    bus.in_len = len;
    bus.softmaxInput = x;
    bus.in_valid = 1'b1;
    check({nm, " in_ready"}, longint'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask
  task automatic wait_out(string nm, vout_t y, int lat);
    int n = 0;
    while (!bus.out_valid && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({nm, " latency"}, longint'(n), longint'(lat));
    checkv({nm, " outputs"}, bus.softmaxOutput, y);
  endtask
  task automatic ack(string nm, int hold);
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({nm, " out_valid after ack"}, longint'(bus.out_valid), 0);
  endtask
  initial begin
    vin_t x;
    vout_t y;
    int lat, seen;
    logic [IW-1:0] base;
    logic [LW-1:0] len;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_len = '0;
    bus.softmaxInput = '0;
    rst_n = 1'b0;
    tab[0] = '{4'd10, {DATACOUNT{8'h14}}, {DATACOUNT{16'h0199}}, 43};
    x = '0; x[0] = 8'hFC; y = '0; y[0] = 16'h044D; y[1] = 16'h0BB2;
    tab[1] = '{4'd2, x, y, 19};
    x = {DATACOUNT{8'h7F}}; x[0] = 8'h80; y = '0; y[0] = 16'h1000;
    tab[2] = '{4'd1, x, y, 16};
    tab[3] = '{4'd0, {DATACOUNT{8'h14}}, {DATACOUNT{16'h0199}}, 43};
    tab[4] = '{4'd15, {DATACOUNT{8'h14}}, {DATACOUNT{16'h0199}}, 43};
    x = {DATACOUNT{8'h80}}; x[3] = 8'h7F; y = '0; y[3] = 16'h1000;
    tab[5] = '{4'd10, x, y, 43};
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", longint'(bus.in_ready), 1);
    check("reset out_valid", longint'(bus.out_valid), 0);
    checkv("reset outputs", bus.softmaxOutput, '0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send($sformatf("tab%0d", i), tab[i].len, tab[i].x);
      wait_out($sformatf("tab%0d", i), tab[i].y, tab[i].lat);
      ack($sformatf("tab%0d", i), 0);
    end
    for (int i = 0; i < DATACOUNT; i++) x[i] = IW'(i * 3);
    model(4'd5, x, y, lat);
    send("hold", 4'd5, x);
    wait_out("hold", y, lat);
    bus.in_valid = 1'b1;
    bus.in_len = 4'd3;
    bus.softmaxInput = ~x;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold%0d out_valid", c), longint'(bus.out_valid), 1);
      check($sformatf("hold%0d in_ready", c), longint'(bus.in_ready), 0);
      checkv($sformatf("hold%0d outputs", c), bus.softmaxOutput, y);
    end
    bus.in_valid = 1'b0;
    ack("hold", 0);
    check("post-ack in_ready", longint'(bus.in_ready), 1);
    checkv("post-ack outputs kept", bus.softmaxOutput, y);
    send("rst", 4'd10, {DATACOUNT{8'h14}});
    repeat (25) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midrst in_ready", longint'(bus.in_ready), 1);
    check("midrst out_valid", longint'(bus.out_valid), 0);
    checkv("midrst outputs", bus.softmaxOutput, '0);
    seen = 0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    check("midrst no stale result", longint'(seen), 0);
    for (int v = 0; v < 30; v++) begin
      len = LW'($urandom_range(0, 15));
      base = IW'($urandom);
      for (int i = 0; i < DATACOUNT; i++) x[i] = base + IW'($urandom_range(0, 4 << (v % 5)));
      model(len, x, y, lat);
      send($sformatf("rnd%0d", v), len, x);
      wait_out($sformatf("rnd%0d", v), y, lat);
      ack($sformatf("rnd%0d", v), $urandom_range(0, 3));
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
